// File: rtl/mpu_pkg.sv
// Shared encodings and layout helper for the MPU element-wise unit.
// No logic or timing of its own.
package mpu_pkg;

  localparam int MPU_SIZE  = 5;
  localparam int MPU_WIDTH = 8;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MIN = 2'b10,
    OP_MAX = 2'b11
  } mpu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } mpu_state_e;

  // Bit offset of element (i,j) in a flattened matrix.
  function automatic int elem_off(input int i, input int j,
                                  input int size = MPU_SIZE,
                                  input int width = MPU_WIDTH);
    return width * (i + size * j);
  endfunction

endpackage

// File: rtl/mpu_lane_alu.sv
// Single-element signed ADD/SUB/MIN/MAX with wrap or saturate and overflow flag.
// Purely combinational; no handshake.
module mpu_lane_alu
  import mpu_pkg::*;
#(
  parameter int WIDTH = MPU_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       operation,
  input  logic             saturate,
  output logic [WIDTH-1:0] y,
  output logic             ovf
);

  logic [WIDTH:0] a_x;
  logic [WIDTH:0] b_x;
  logic [WIDTH:0] sum;
  logic           a_lt_b;

  always_comb begin
    a_x    = {a[WIDTH-1], a};
    b_x    = {b[WIDTH-1], b};
    sum    = (operation == OP_SUB) ? (a_x - b_x) : (a_x + b_x);
    a_lt_b = $signed(a) < $signed(b);
    y      = sum[WIDTH-1:0];
    ovf    = 1'b0;
    case (operation)
      OP_ADD, OP_SUB: begin
        // Sign bit of the wide sum disagreeing with the narrow sign means out of range.
        ovf = sum[WIDTH] != sum[WIDTH-1];
        if (ovf && saturate)
          y = sum[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
      end
      OP_MIN:  y = a_lt_b ? a : b;
      default: y = a_lt_b ? b : a;
    endcase
  end

endmodule

// File: rtl/mpu_elementwise.sv
// Element-wise matrix ALU, LANES elements per beat under start/busy/done.
// Latency: start -> done after SIZE*SIZE/LANES beats + 1; start ignored while busy.
module mpu_elementwise
  import mpu_pkg::*;
#(
  parameter int SIZE  = MPU_SIZE,
  parameter int WIDTH = MPU_WIDTH,
  parameter int LANES = 5
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        start,
  input  logic [1:0]                  operation,
  input  logic                        saturate,
  input  logic [SIZE*SIZE*WIDTH-1:0]  matrix_a,
  input  logic [SIZE*SIZE*WIDTH-1:0]  matrix_b,
  output logic                        busy,
  output logic                        done,
  output logic                        overflow,
  output logic [SIZE*SIZE*WIDTH-1:0]  result
);

  localparam int N     = SIZE * SIZE;
  localparam int BEATS = N / LANES;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int LAST  = BEATS - 1;

  mpu_state_e         state_q, state_d;
  logic [BW-1:0]      beat_q;
  logic [N*WIDTH-1:0] a_q, b_q;
  logic [1:0]         op_q;
  logic               sat_q;
  logic               accept;

  logic [WIDTH-1:0]   lane_a [LANES];
  logic [WIDTH-1:0]   lane_b [LANES];
  logic [WIDTH-1:0]   lane_y [LANES];
  logic [LANES-1:0]   lane_ovf;

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        accept  = start;
        state_d = start ? ST_RUN : ST_IDLE;
      end
      ST_RUN:  if (beat_q == BW'(LAST)) state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Route the current beat's slice of the latched operands to the lanes.
  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      lane_a[k] = '0;
      lane_b[k] = '0;
      for (int bt = 0; bt < BEATS; bt++) begin
        if (beat_q == BW'(bt)) begin
          lane_a[k] = a_q[(bt*LANES+k)*WIDTH +: WIDTH];
          lane_b[k] = b_q[(bt*LANES+k)*WIDTH +: WIDTH];
        end
      end
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    mpu_lane_alu #(.WIDTH(WIDTH)) u_alu (
      .a         (lane_a[k]),
      .b         (lane_b[k]),
      .operation (op_q),
      .saturate  (sat_q),
      .y         (lane_y[k]),
      .ovf       (lane_ovf[k])
    );
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      beat_q   <= '0;
      overflow <= 1'b0;
      result   <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= OP_ADD;
      sat_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_q      <= matrix_a;
        b_q      <= matrix_b;
        op_q     <= operation;
        sat_q    <= saturate;
        beat_q   <= '0;
        overflow <= 1'b0;
      end else if (state_q == ST_RUN) begin
        overflow <= overflow | (|lane_ovf);
        if (beat_q != BW'(LAST)) beat_q <= beat_q + 1'b1;
        for (int bt = 0; bt < BEATS; bt++)
          for (int k = 0; k < LANES; k++)
            if (beat_q == BW'(bt)) result[(bt*LANES+k)*WIDTH +: WIDTH] <= lane_y[k];
      end
    end
  end

  assign busy = (state_q == ST_RUN);
  assign done = (state_q == ST_DONE);

endmodule
